// File: rtl/ntt_stage_feeder.sv
// ntt_stage_feeder
//   Upstream feeder for one NTT butterfly stage. Loads the stage's twiddle
//   RAM, collects one frame of N coefficients into a local frame buffer, then
//   plays the frame into the stage as a single gap-free burst followed by a
//   FLUSH-cycle zero tail that drains the stage pipeline. The stage cannot
//   stall, so all source stalls are absorbed here before the burst starts.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   reload              : one-cycle request to reload the twiddle RAM
//   tw_valid/data/ready : twiddle input stream
//   coef_valid/data/ready : coefficient input stream
//   full_ram            : twiddle RAM reports every entry written
//   write_en/addr/data  : twiddle RAM write port (registered)
//   start/incoming_data : stage inputs (registered)
//   busy                : high while the burst/tail is being driven
//   done                : one-cycle pulse after the last tail cycle
//
// Build option
//   FEEDER_REDUCE_EN : store each coefficient after one conditional
//                      subtraction of MODULUS (twiddles are never reduced).
module ntt_stage_feeder #(
  parameter int W                    = 32,
  parameter int MODULUS              = 7681,
  parameter int N                    = 16,
  parameter int twiddle_buffer_depth = 8,
  parameter int FLUSH                = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    reload,
  input  logic                                    tw_valid,
  input  logic [W-1:0]                            tw_data,
  output logic                                    tw_ready,
  input  logic                                    coef_valid,
  input  logic [W-1:0]                            coef_data,
  output logic                                    coef_ready,
  input  logic                                    full_ram,
  output logic                                    write_en,
  output logic [$clog2(twiddle_buffer_depth)-1:0] write_addr,
  output logic [W-1:0]                            write_data,
  output logic                                    start,
  output logic [W-1:0]                            incoming_data,
  output logic                                    busy,
  output logic                                    done
);

  localparam int AW = $clog2(twiddle_buffer_depth);
  localparam int PW = $clog2(N);
  localparam int RW = $clog2(N + 1);
  localparam int FW = $clog2(FLUSH + 1);
  localparam logic [W-1:0] MOD_W = W'(MODULUS);

`ifdef FEEDER_REDUCE_EN
  localparam bit RED_EN = 1'b1;
`else
  localparam bit RED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_LOAD_TW  = 3'd0,
    ST_WAIT_RAM = 3'd1,
    ST_FILL     = 3'd2,
    ST_RUN      = 3'd3,
    ST_FLUSH    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   tw_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [RW-1:0]   rd_ptr;      // words already emitted in this burst
  logic [FW-1:0]   fl_cnt;      // tail cycle currently being driven (1-based)
  logic            reload_pend;
  logic [W-1:0]    fbuf [N];

  logic            tw_hs, coef_hs, reload_now, flush_exit;
  logic [W-1:0]    coef_store;
  logic [PW-1:0]   rd_idx;

  assign tw_ready   = (state == ST_LOAD_TW);
  assign coef_ready = (state == ST_FILL);
  assign tw_hs      = tw_valid & tw_ready;
  assign coef_hs    = coef_valid & coef_ready;

  // A reload before the first word of a frame is taken at once; it wins over
  // a coincident coefficient handshake, which is then not stored.
  assign reload_now = reload && (state == ST_FILL) && (wr_ptr == '0);
  assign flush_exit = (state == ST_FLUSH) && (fl_cnt == FW'(FLUSH));

  // Single conditional subtraction; folds away when RED_EN is 0.
  assign coef_store = (RED_EN && (coef_data >= MOD_W)) ? coef_data - MOD_W : coef_data;

  // First burst word comes from slot 0; afterwards rd_ptr names the next slot.
  assign rd_idx = (state == ST_RUN) ? rd_ptr[PW-1:0] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD_TW:  if (tw_hs && tw_cnt == AW'(twiddle_buffer_depth - 1)) state_nxt = ST_WAIT_RAM;
      ST_WAIT_RAM: if (full_ram) state_nxt = ST_FILL;
      ST_FILL: begin
        if (reload_now)                              state_nxt = ST_LOAD_TW;
        else if (coef_hs && wr_ptr == PW'(N - 1))    state_nxt = ST_RUN;
      end
      ST_RUN:      if (rd_ptr == RW'(N)) state_nxt = ST_FLUSH;
      ST_FLUSH:    if (flush_exit) state_nxt = (reload_pend || reload) ? ST_LOAD_TW : ST_FILL;
      default:     state_nxt = ST_LOAD_TW;
    endcase
  end

  // Frame buffer: plain memory, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && coef_hs && !reload_now) fbuf[wr_ptr] <= coef_store;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD_TW;
      tw_cnt        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fl_cnt        <= '0;
      reload_pend   <= 1'b0;
      write_en      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      start         <= 1'b0;
      incoming_data <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state    <= state_nxt;

      // twiddle write lands the cycle after its handshake
      write_en <= tw_hs;
      if (tw_hs) begin
        write_addr <= tw_cnt;
        write_data <= tw_data;
        tw_cnt     <= tw_cnt + 1'b1;
      end

      if (coef_hs && !reload_now) wr_ptr <= wr_ptr + 1'b1;

      // reload arriving mid-frame is deferred to the end of the tail
      if (reload && ((state == ST_RUN) || (state == ST_FLUSH) ||
                     ((state == ST_FILL) && (wr_ptr != '0))))
        reload_pend <= 1'b1;

      if (reload_now) tw_cnt <= '0;

      // stage outputs are registered from the next state so they line up
      // with the state they belong to
      start <= (state_nxt == ST_RUN) || (state_nxt == ST_FLUSH);
      busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_FLUSH);

      if (state_nxt == ST_RUN) begin
        incoming_data <= fbuf[rd_idx];
        rd_ptr        <= (state == ST_RUN) ? rd_ptr + 1'b1 : RW'(1);
      end else begin
        incoming_data <= '0;
      end

      if (state_nxt == ST_FLUSH)
        fl_cnt <= (state == ST_FLUSH) ? fl_cnt + 1'b1 : FW'(1);

      done <= flush_exit;

      if (flush_exit) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fl_cnt      <= '0;
        reload_pend <= 1'b0;
        tw_cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_stage_feeder.sv
// Self-checking bench for ntt_stage_feeder: stimulus tasks push expected
// twiddle writes and burst words into queues; a negedge monitor pops and
// compares whenever the DUT presents a write or a start cycle.
module tb_ntt_stage_feeder;
  localparam int W       = 32;
  localparam int MODULUS = 7681;
  localparam int N       = 16;
  localparam int D       = 8;
  localparam int FL      = 8;
  localparam int AW      = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload = 1'b0;
  logic          tw_valid = 1'b0;
  logic [W-1:0]  tw_data = '0;
  logic          tw_ready;
  logic          coef_valid = 1'b0;
  logic [W-1:0]  coef_data = '0;
  logic          coef_ready;
  logic          full_ram = 1'b0;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [W-1:0]  write_data;
  logic          start;
  logic [W-1:0]  incoming_data;
  logic          busy;
  logic          done;

  ntt_stage_feeder #(.W(W), .MODULUS(MODULUS), .N(N), .twiddle_buffer_depth(D), .FLUSH(FL)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_ready(tw_ready),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .full_ram(full_ram),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .start(start), .incoming_data(incoming_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [W-1:0] d; } tw_exp_t;

  tw_exp_t      tw_q[$];
  logic [W-1:0] st_q[$];
  logic [W-1:0] fr [N];
  int n_cmp = 0, n_bad = 0;
  int tw_addr_m = 0;
  int done_seen = 0, done_exp = 0;
  int run_len = 0;
  bit mon_en = 0, aborting = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference storage rule: one conditional subtraction when reduction is built in.
  function automatic logic [W-1:0] ref_store(input logic [W-1:0] x);
`ifdef FEEDER_REDUCE_EN
    return (x >= W'(MODULUS)) ? x - W'(MODULUS) : x;
`else
    return x;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (write_en) begin
        if (tw_q.size() == 0) fail("unexpected_tw_write");
        else begin
          tw_exp_t e;
          e = tw_q.pop_front();
          check("tw_addr", W'(write_addr), W'(e.a));
          check("tw_data", write_data, e.d);
        end
      end
      if (start) begin
        check("busy_in_burst", W'(busy), 1);
        if (st_q.size() == 0) fail("unexpected_start");
        else check("stream_data", incoming_data, st_q.pop_front());
        run_len++;
      end else if (run_len > 0) begin
        check("busy_after_burst", W'(busy), 0);
        if (aborting) check("no_done_after_reset", W'(done), 0);
        else begin
          check("burst_len", W'(run_len), W'(N + FL));
          check("done_pulse", W'(done), 1);
          if (done) done_seen++;
        end
        run_len = 0;
      end else if (done) begin
        fail("stray_done");
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_tw(input logic [W-1:0] d);
    int t = 0;
    tw_valid = 1'b1;
    tw_data  = d;
    while (!tw_ready && t < 2000) begin @(negedge clk); t++; end
    if (!tw_ready) begin fail("tw_ready_timeout"); tw_valid = 1'b0; return; end
    tw_q.push_back('{a: AW'(tw_addr_m), d: d});
    tw_addr_m = (tw_addr_m + 1) % D;
    @(negedge clk);
    tw_valid = 1'b0;
  endtask

  task automatic send_coef(input logic [W-1:0] d, input bit gap);
    int t = 0;
    coef_valid = 1'b1;
    coef_data  = d;
    while (!coef_ready && t < 2000) begin @(negedge clk); t++; end
    if (!coef_ready) begin fail("coef_ready_timeout"); coef_valid = 1'b0; return; end
    @(negedge clk);
    coef_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  // mode 0: no gaps, 1: gap after every word, 2: random gaps
  task automatic send_frame(input int mode);
    foreach (fr[i]) st_q.push_back(ref_store(fr[i]));
    for (int i = 0; i < FL; i++) st_q.push_back('0);
    for (int i = 0; i < N; i++) begin
      bit g;
      g = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == N - 1) g = 1'b0;
      send_coef(fr[i], g);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 500) begin @(negedge clk); t++; end
    if (!done) fail("done_timeout");
  endtask

  task automatic load_twiddles(input bit seq);
    for (int i = 0; i < D; i++) send_tw(seq ? W'(i + 1) : W'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_write_en", W'(write_en), 0);
    check("rst_write_addr", W'(write_addr), 0);
    check("rst_write_data", write_data, 0);
    check("rst_start", W'(start), 0);
    check("rst_incoming", incoming_data, 0);
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_tw_ready", W'(tw_ready), 1);
    check("rst_coef_ready", W'(coef_ready), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // twiddles 1..8 back-to-back, then hold in WAIT_RAM
    load_twiddles(1'b1);
    repeat (5) begin
      check("wait_tw_ready", W'(tw_ready), 0);
      check("wait_coef_ready", W'(coef_ready), 0);
      @(negedge clk);
    end
    full_ram = 1'b1;

    // frame 0..15 with toggling valid
    foreach (fr[i]) fr[i] = W'(i);
    send_frame(1);
    done_exp++;
    wait_done();
    check("coef_ready_at_done", W'(coef_ready), 1);

    // two frames back-to-back, no reload
    foreach (fr[i]) fr[i] = W'(100 + i);
    send_frame(0);
    done_exp++;
    foreach (fr[i]) fr[i] = W'(200 + i);
    send_frame(0);
    done_exp++;
    wait_done();

    // reload in 5th RUN cycle; send_frame returns in RUN cycle 1
    foreach (fr[i]) fr[i] = $urandom;
    send_frame(0);
    done_exp++;
    repeat (4) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    full_ram = 1'b0;
    tw_addr_m = 0;
    wait_done();
    check("tw_ready_after_reload", W'(tw_ready), 1);
    check("coef_ready_after_reload", W'(coef_ready), 0);
    load_twiddles(1'b0);
    full_ram = 1'b1;

    // reset in 3rd FLUSH cycle: RUN1 + N negedges = FLUSH1
    foreach (fr[i]) fr[i] = $urandom;
    send_frame(2);
    repeat (N + 2) @(negedge clk);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_start", W'(start), 0);
    check("abort_busy", W'(busy), 0);
    check("abort_tw_ready", W'(tw_ready), 1);
    check("abort_done", W'(done), 0);
    st_q.delete();
    tw_addr_m = 0;
    @(negedge clk);
    aborting = 1'b0;
    load_twiddles(1'b0);

    // modulus boundary values plus random values around the modulus
    fr[0] = W'(MODULUS);
    fr[1] = W'(MODULUS + 9);
    fr[2] = W'(MODULUS - 1);
    for (int i = 3; i < N; i++) fr[i] = W'($urandom_range(0, 2 * MODULUS - 1));
    send_frame(2);
    done_exp++;

    // random frames with random stalls
    for (int f = 0; f < 3; f++) begin
      foreach (fr[i]) fr[i] = ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 2 * MODULUS));
      send_frame(2);
      done_exp++;
    end
    wait_done();
    repeat (3) @(negedge clk);

    check("done_count", W'(done_seen), W'(done_exp));
    check("stream_queue_empty", W'(st_q.size()), 0);
    check("tw_queue_empty", W'(tw_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
